regfile_2r1w: RTL and testbench
===============================

# regfile_2r1w

Parametrised register file for the FIFO/storage subsystem: one byte-enabled write port, two independent registered read ports, and a hardware clear sequencer that zeroes every entry after reset or on request. Generalises the fixed 8×32 single-read register file to arbitrary width and depth. It serves as the storage core for multi-consumer FIFOs and small lookup tables.

## Interface
- DATA_W, 32: word width in bits; must be a multiple of 8.
- DEPTH, 8: number of entries, ≥2; need not be a power of two.
- ADDR_W, $clog2(DEPTH): address width (derived, not overridden).
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- clr  input  1  request to re-zero all entries (single-cycle pulse sufficient).
- busy  output  1  clear sequence in progress; port accesses ignored.
- wr_en  input  1  write strobe.
- wr_addr  input  ADDR_W  write address.
- wr_be  input  DATA_W/8  byte enables; bit i covers wr_data[8i+7:8i].
- wr_data  input  DATA_W  write data.
- rd0_en, rd1_en  input  1  read strobe per port.
- rd0_addr, rd1_addr  input  ADDR_W  read address per port.
- rd0_data, rd1_data  output  DATA_W  registered read data.
- rd0_valid, rd1_valid  output  1  pulses one cycle when rdN_data updated.

## Operation
- FSM states: CLEAR, RUN. Clear counter clr_idx, ADDR_W bits.
- Reset (rst_n low at an edge): state←CLEAR, clr_idx←0, busy←1, rdN_data←0, rdN_valid←0. Memory contents not reset directly; the CLEAR pass zeroes them.
- CLEAR: each edge writes 0 to mem[clr_idx], clr_idx increments. At clr_idx==DEPTH-1 → RUN, busy←0.
- CLEAR: wr_en and rdN_en ignored; rdN_valid stays 0; rdN_data holds.
- RUN: clr sampled high → CLEAR with clr_idx←0. Any access presented in that same cycle is still performed.
- clr in CLEAR: restarts clr_idx at 0.
- Write (RUN, wr_en, wr_addr<DEPTH): mem[wr_addr] byte i ← wr_data byte i where wr_be[i]=1; other bytes kept. wr_be all-zero = no change.
- Read (RUN, rdN_en): rdN_data ← mem[rdN_addr], rdN_valid←1 next cycle. rdN_en low: rdN_valid←0, rdN_data holds.
- Out-of-range address (≥DEPTH): write dropped; read returns 0 with rdN_valid=1.
- Both read ports may target the same or any address concurrently; no conflicts.
- Write and read to same address in same cycle: see Configuration.

## Timing
- Read latency: 1 cycle, address at edge k → data/valid after edge k+1.
- Write visible to reads presented at edge k+1 onward.
- After rst_n rises, busy stays high for exactly DEPTH edges; first accepted access is on edge DEPTH+1 after release.
- clr accepted at edge k → busy high from after edge k for DEPTH edges.
- rst_n low mid-clear or mid-run: immediate restart per reset rule.

## Configuration
- REGFILE_BYPASS_EN defined: same-cycle write+read to one address returns the merged new word (old bytes where wr_be=0, wr_data bytes where 1).
- Undefined: read returns the pre-write word (read-before-write); new data visible one cycle later.
- Bypass is per read port, independent for each.

## Structure
- Package regfile_pkg: state enum (CLEAR, RUN), byte-merge function (old, new, be), localparam BE_W=DATA_W/8.
- One sub-module, regfile_rd_port: address range check, bypass mux, output registers; instantiated twice.
- Memory array, write logic and clear FSM in top module.

## Test plan
- Reset, DEPTH=8: release rst_n → busy high 8 cycles, then 0; read all addresses → 0x00000000, rdN_valid each 1 cycle later.
- Write addr 3 data 0xDEADBEEF be=0xF, then addr 3 data 0x11223344 be=0x5 → read 0xDE22BE44.
- Same cycle write addr 5 = 0xCAFEF00D be=0xF, rd0 addr 5 (old 0): with REGFILE_BYPASS_EN → 0xCAFEF00D; without → 0, next read → 0xCAFEF00D.
- rd0 addr 2, rd1 addr 2 and rd1 addr 6 across cycles: both ports return correct independent data, valid pulses match enables.
- DEPTH=6: write addr 7 dropped, read addr 7 → 0 valid=1; addr 0–5 unaffected.
- Fill memory, pulse clr, assert wr_en during busy → write ignored, busy 6/8 cycles, all reads 0; rst_n low mid-clear restarts full DEPTH count.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the 2-read/1-write register file.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_DEPTH  = 8;
    localparam int unsigned BE_W       = DEF_DATA_W / 8;

    function automatic logic [7:0] byte_merge(
        input logic [7:0] old_b,
        input logic [7:0] new_b,
        input logic       be
    );
        return be ? new_b : old_b;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: range check, optional write bypass (REGFILE_BYPASS_EN), output regs.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter  int unsigned DATA_W = DEF_DATA_W,
    parameter  int unsigned DEPTH  = DEF_DEPTH,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W-1:0]   mem [DEPTH],
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid
);

    localparam int unsigned       NB      = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] rd_word;
    logic              rd_in_range;

    assign rd_in_range = {1'b0, rd_addr} < DEPTH_V;

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[rd_addr];
            if (wr_en && (wr_addr == rd_addr)) begin
                for (int unsigned i = 0; i < NB; i++) begin
                    rd_word[8*i +: 8] = byte_merge(rd_word[8*i +: 8], wr_data[8*i +: 8], wr_be[i]);
                end
            end
        end
    end
`else
    logic unused_wr;
    assign unused_wr = ^{wr_en, wr_addr, wr_be, wr_data};

    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[rd_addr];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= run && rd_en;
            if (run && rd_en) begin
                rd_data <= rd_word;
            end
        end
    end

endmodule

// File: rtl/regfile_2r1w.sv
// Byte-enabled 1W/2R register file with hardware clear sequencer.
// Optional same-cycle write->read bypass: define REGFILE_BYPASS_EN.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter  int unsigned DATA_W = DEF_DATA_W,
    parameter  int unsigned DEPTH  = DEF_DEPTH,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    output logic                busy,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                rd0_en,
    input  logic [ADDR_W-1:0]   rd0_addr,
    output logic [DATA_W-1:0]   rd0_data,
    output logic                rd0_valid,
    input  logic                rd1_en,
    input  logic [ADDR_W-1:0]   rd1_addr,
    output logic [DATA_W-1:0]   rd1_data,
    output logic                rd1_valid
);

    localparam int unsigned       NB       = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_idx, clr_idx_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              run;
    logic              wr_acc;
    logic              wr_ok;

    assign run    = (state == RUN);
    assign busy   = ~run;
    assign wr_acc = run && wr_en;
    assign wr_ok  = wr_acc && ({1'b0, wr_addr} < DEPTH_V);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        case (state)
            CLEAR: begin
                if (clr) begin
                    clr_idx_nxt = '0;
                end else if (clr_idx == LAST_IDX) begin
                    state_nxt   = RUN;
                    clr_idx_nxt = '0;
                end else begin
                    clr_idx_nxt = clr_idx + 1'b1;
                end
            end
            RUN: begin
                if (clr) begin
                    state_nxt   = CLEAR;
                    clr_idx_nxt = '0;
                end
            end
            default: begin
                state_nxt   = CLEAR;
                clr_idx_nxt = '0;
            end
        endcase
    end

    // Storage is never reset; the CLEAR pass is what zeroes it.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_idx] <= '0;
        end else if (rst_n && wr_ok) begin
            for (int unsigned i = 0; i < NB; i++) begin
                mem[wr_addr][8*i +: 8] <= byte_merge(mem[wr_addr][8*i +: 8], wr_data[8*i +: 8], wr_be[i]);
            end
        end
    end

    regfile_rd_port #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_rd0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .rd_en    (rd0_en),
        .rd_addr  (rd0_addr),
        .wr_en    (wr_acc),
        .wr_addr  (wr_addr),
        .wr_be    (wr_be),
        .wr_data  (wr_data),
        .mem      (mem),
        .rd_data  (rd0_data),
        .rd_valid (rd0_valid)
    );

    regfile_rd_port #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_rd1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .rd_en    (rd1_en),
        .rd_addr  (rd1_addr),
        .wr_en    (wr_acc),
        .wr_addr  (wr_addr),
        .wr_be    (wr_be),
        .wr_data  (wr_data),
        .mem      (mem),
        .rd_data  (rd1_data),
        .rd_valid (rd1_valid)
    );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed self-checking bench: DEPTH=8 and DEPTH=6 instances driven with shared stimulus.
module tb_regfile_2r1w;
    import regfile_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, clr, wr_en, rd0_en, rd1_en;
    logic [2:0]      wr_addr, rd0_addr, rd1_addr;
    logic [BE_W-1:0] wr_be;
    logic [31:0]     wr_data;

    logic        d8_busy, d8_v0, d8_v1, d6_busy, d6_v0, d6_v1;
    logic [31:0] d8_q0, d8_q1, d6_q0, d6_q1;

    regfile_2r1w #(.DATA_W(32), .DEPTH(8)) u_rf8 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(d8_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(d8_q0), .rd0_valid(d8_v0),
        .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(d8_q1), .rd1_valid(d8_v1)
    );

    regfile_2r1w #(.DATA_W(32), .DEPTH(6)) u_rf6 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(d6_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
        .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(d6_q0), .rd0_valid(d6_v0),
        .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(d6_q1), .rd1_valid(d6_v1)
    );

`ifdef REGFILE_BYPASS_EN
    localparam logic [31:0] SAME5 = 32'hCAFEF00D;
    localparam logic [31:0] SAME3 = 32'hDEBBCC44;
`else
    localparam logic [31:0] SAME5 = 32'h00000000;
    localparam logic [31:0] SAME3 = 32'hDE22BE44;
`endif

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clr = 1'b0; wr_en = 1'b0; rd0_en = 1'b0; rd1_en = 1'b0;
    endtask

    task automatic write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    endtask

    // expected post-clear busy profile for both depths
    task automatic check_clear_pass(input string tag);
        for (int e = 1; e <= 8; e++) begin
            tick();
            check({tag, "_busy8"}, 32'(d8_busy), 32'(e < 8));
            check({tag, "_busy6"}, 32'(d6_busy), 32'(e < 6));
        end
    endtask

    logic [31:0] exp8 [8];
    logic [31:0] exp6 [8];

    initial begin
        rst_n = 1'b0; wr_addr = '0; rd0_addr = '0; rd1_addr = '0; wr_be = '0; wr_data = '0;
        idle();
        tick(); tick();
        check("rst_busy8", 32'(d8_busy), 32'd1);
        check("rst_busy6", 32'(d6_busy), 32'd1);
        check("rst_q0_8", d8_q0, 32'h0);
        check("rst_q1_6", d6_q1, 32'h0);
        check("rst_v0_8", 32'(d8_v0), 32'd0);
        check("rst_v1_6", 32'(d6_v1), 32'd0);

        rst_n = 1'b1;
        check_clear_pass("init");

        // all addresses read back zero on both ports, including out-of-range on DEPTH=6
        for (int a = 0; a < 8; a++) begin
            rd0_en = 1'b1; rd0_addr = 3'(a); rd1_en = 1'b1; rd1_addr = 3'(7 - a);
            tick();
            check("zero_q0_8", d8_q0, 32'h0);
            check("zero_q1_8", d8_q1, 32'h0);
            check("zero_q0_6", d6_q0, 32'h0);
            check("zero_q1_6", d6_q1, 32'h0);
            check("zero_v_8", {30'b0, d8_v0, d8_v1}, 32'd3);
            check("zero_v_6", {30'b0, d6_v0, d6_v1}, 32'd3);
        end
        idle();
        tick();
        check("noread_v_8", {30'b0, d8_v0, d8_v1}, 32'd0);

        // byte-enable merge
        write(3'd3, 32'hDEADBEEF, 4'hF); tick();
        write(3'd3, 32'h11223344, 4'h5); tick();
        idle(); rd0_en = 1'b1; rd0_addr = 3'd3; tick();
        check("merge_8", d8_q0, 32'hDE22BE44);
        check("merge_6", d6_q0, 32'hDE22BE44);

        // same-cycle write + read on both ports
        write(3'd5, 32'hCAFEF00D, 4'hF);
        rd0_en = 1'b1; rd0_addr = 3'd5; rd1_en = 1'b1; rd1_addr = 3'd5;
        tick();
        check("same5_q0_8", d8_q0, SAME5);
        check("same5_q1_6", d6_q1, SAME5);
        idle(); rd0_en = 1'b1; rd0_addr = 3'd5; tick();
        check("after5_q0_8", d8_q0, 32'hCAFEF00D);
        check("after5_q0_6", d6_q0, 32'hCAFEF00D);

        // partial-enable same-cycle write on port 1 only; port 0 holds
        idle(); write(3'd3, 32'hAABBCCDD, 4'h6); rd1_en = 1'b1; rd1_addr = 3'd3; tick();
        check("same3_q1_8", d8_q1, SAME3);
        check("same3_q1_6", d6_q1, SAME3);
        check("hold_q0_8", d8_q0, 32'hCAFEF00D);
        check("hold_v0_8", 32'(d8_v0), 32'd0);

        // independent ports; addr 6 and 7 are out of range on DEPTH=6
        idle(); write(3'd2, 32'h22222222, 4'hF); tick();
        write(3'd6, 32'h66666666, 4'hF); tick();
        write(3'd7, 32'h77777777, 4'hF); tick();
        idle(); rd0_en = 1'b1; rd0_addr = 3'd2; rd1_en = 1'b1; rd1_addr = 3'd6; tick();
        check("ind_q0_8", d8_q0, 32'h22222222);
        check("ind_q1_8", d8_q1, 32'h66666666);
        check("ind_q1_6", d6_q1, 32'h0);
        check("ind_v1_6", 32'(d6_v1), 32'd1);
        idle(); rd1_en = 1'b1; rd1_addr = 3'd2; tick();
        check("ind2_q1_8", d8_q1, 32'h22222222);
        check("ind2_q0_8", d8_q0, 32'h22222222);
        check("ind2_v_8", {30'b0, d8_v0, d8_v1}, 32'd1);

        exp8 = '{32'h0, 32'h0, 32'h22222222, 32'hDEBBCC44, 32'h0, 32'hCAFEF00D, 32'h66666666, 32'h77777777};
        exp6 = '{32'h0, 32'h0, 32'h22222222, 32'hDEBBCC44, 32'h0, 32'hCAFEF00D, 32'h0, 32'h0};
        for (int a = 0; a < 8; a++) begin
            idle(); rd0_en = 1'b1; rd0_addr = 3'(a); tick();
            check("scan_8", d8_q0, exp8[a]);
            check("scan_6", d6_q0, exp6[a]);
            check("scan_v6", 32'(d6_v0), 32'd1);
        end

        // clr with a concurrent read; accesses during busy are ignored
        idle(); clr = 1'b1; rd0_en = 1'b1; rd0_addr = 3'd3; tick();
        check("clr_rd_8", d8_q0, 32'hDEBBCC44);
        check("clr_busy8", 32'(d8_busy), 32'd1);
        check("clr_busy6", 32'(d6_busy), 32'd1);
        idle(); write(3'd1, 32'hFFFFFFFF, 4'hF); rd0_en = 1'b1; rd0_addr = 3'd1;
        for (int e = 1; e <= 8; e++) begin
            if (e == 6) idle();
            tick();
            check("cb_busy8", 32'(d8_busy), 32'(e < 8));
            check("cb_busy6", 32'(d6_busy), 32'(e < 6));
            if (e < 6) begin
                check("cb_v0_8", 32'(d8_v0), 32'd0);
                check("cb_v0_6", 32'(d6_v0), 32'd0);
            end
        end
        for (int a = 0; a < 8; a++) begin
            idle(); rd0_en = 1'b1; rd0_addr = 3'(a); rd1_en = 1'b1; rd1_addr = 3'(a); tick();
            check("cleared_8", d8_q0, 32'h0);
            check("cleared_6", d6_q1, 32'h0);
        end

        // reset in the middle of a clear restarts the full count
        idle(); write(3'd2, 32'hA5A5A5A5, 4'hF); tick();
        idle(); rd0_en = 1'b1; rd0_addr = 3'd2; tick();
        check("a5_8", d8_q0, 32'hA5A5A5A5);
        idle(); clr = 1'b1; tick();
        idle(); tick(); tick(); tick();
        check("midclr_hold_8", d8_q0, 32'hA5A5A5A5);
        rst_n = 1'b0; tick();
        check("midrst_q0_8", d8_q0, 32'h0);
        check("midrst_q0_6", d6_q0, 32'h0);
        check("midrst_busy8", 32'(d8_busy), 32'd1);
        rst_n = 1'b1;
        check_clear_pass("rerun");
        idle(); rd0_en = 1'b1; rd0_addr = 3'd2; tick();
        check("final_8", d8_q0, 32'h0);
        check("final_v_8", 32'(d8_v0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
